// File: rtl/pipe_mux_nx1.sv
// Registered N:1 multiplexer with valid/ready handshake, out-of-range select flagging and a saturating error count.
// Defining PIPE_MUX_SKID_EN adds a one-entry skid buffer so that in_ready comes from a register.
module pipe_mux_nx1 #(
  parameter int N    = 4,
  parameter int W    = 32,
  parameter int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*W-1:0]    in_data,
  input  logic [SELW-1:0]   in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err,
  output logic [7:0]        err_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready on the same side;
  // valid never waits for ready, and a held beat keeps data and valid stable until taken.

  localparam bit              NPOW2 = ((N & (N - 1)) == 0);
  localparam logic [SELW:0]   NLIM  = (SELW + 1)'(N);

  logic [W-1:0] sel_data;
  logic         sel_oor;
  logic         in_xfer;

  // Out-of-range selects fall back to the last input.
  always_comb begin
    sel_data = in_data[(N-1)*W +: W];
    for (int k = 0; k < N - 1; k++) begin
      if (in_sel == SELW'(k)) sel_data = in_data[k*W +: W];
    end
  end

  assign sel_oor = !NPOW2 && ({1'b0, in_sel} >= NLIM);
  assign in_xfer = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      sel_err <= in_xfer && sel_oor;
      if (in_xfer && sel_oor && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef PIPE_MUX_SKID_EN
  logic         skid_empty;
  logic [W-1:0] skid_data;

  assign in_ready = skid_empty;

  // A beat accepted while the output is stalled parks in the skid entry
  // and is handed to the output ahead of any newer beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_empty <= 1'b1;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (!skid_empty) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_empty <= 1'b1;
      end else if (in_xfer) begin
        out_data  <= sel_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_data  <= sel_data;
      skid_empty <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_xfer) begin
      out_data  <= sel_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mux_nx1.sv
// Scoreboard bench for pipe_mux_nx1: an N=3 instance (out-of-range selects) and an N=4 instance
// share one stimulus stream; expected beats are queued by the driver and popped by a monitor.
module tb_pipe_mux_nx1;
  localparam int W = 32;
`ifdef PIPE_MUX_SKID_EN
  localparam int STALL_ACCEPTS = 1;
`else
  localparam int STALL_ACCEPTS = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   w [4];
  logic [4*W-1:0] in_data4;
  logic [3*W-1:0] in_data3;
  logic [1:0]     in_sel = 2'd0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic           in_ready3, in_ready4, out_valid3, out_valid4, sel_err3, sel_err4;
  logic [W-1:0]   out_data3, out_data4;
  logic [7:0]     err_cnt3, err_cnt4;

  logic [W-1:0]   exp3_q[$];
  logic [W-1:0]   exp4_q[$];
  int             checks = 0;
  int             errors = 0;
  int             err_m = 0;
  int             acc_cnt = 0;
  int             a0 = 0;
  int             rst_pulses = 0;
  int             seen_pulses = 0;
  logic           stall3 = 1'b0;
  logic [W-1:0]   hold3 = '0;

  assign in_data4 = {w[3], w[2], w[1], w[0]};
  assign in_data3 = {w[2], w[1], w[0]};

  pipe_mux_nx1 #(.N(3), .W(W)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
    .sel_err(sel_err3), .err_cnt(err_cnt3)
  );

  pipe_mux_nx1 #(.N(4), .W(W)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .sel_err(sel_err4), .err_cnt(err_cnt4)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall3 && (seen_pulses == rst_pulses)) begin
        chk("hold_valid", out_valid3, 1'b1);
        chk("hold_data", out_data3, hold3);
      end
      if (out_valid3 && out_ready) begin
        checks++;
        if (exp3_q.size() == 0) begin
          errors++;
          $display("FAIL dut3_extra_beat: got 0x%0h with no beat expected", out_data3);
        end else begin
          checks--;
          chk("dut3_data", out_data3, exp3_q.pop_front());
        end
      end
      if (out_valid4 && out_ready) begin
        checks++;
        if (exp4_q.size() == 0) begin
          errors++;
          $display("FAIL dut4_extra_beat: got 0x%0h with no beat expected", out_data4);
        end else begin
          checks--;
          chk("dut4_data", out_data4, exp4_q.pop_front());
        end
      end
      if (in_valid && in_ready3) acc_cnt++;
      stall3 = out_valid3 && !out_ready;
      hold3  = out_data3;
    end else begin
      stall3 = 1'b0;
    end
    seen_pulses = rst_pulses;
  end

  // Driver tasks
  task automatic send(input logic [1:0] sel);
    int guard = 0;
    in_sel   = sel;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready3 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready3) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready 0 for %0d cycles, required 1", guard);
      in_valid = 1'b0;
      return;
    end
    exp3_q.push_back((sel == 2'd3) ? w[2] : w[sel]);
    exp4_q.push_back(w[sel]);
    if (sel == 2'd3 && err_m < 255) err_m++;
    @(posedge clk);
    #1;
    chk("sel_err", sel_err3, (sel == 2'd3));
    chk("err_cnt", err_cnt3, err_m);
    chk("sel_err_pow2", sel_err4, 1'b0);
    chk("err_cnt_pow2", err_cnt4, 8'd0);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("sel_err_idle", sel_err3, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp3_q.size() != 0 || exp4_q.size() != 0) && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk("drain_q3", exp3_q.size(), 0);
    chk("drain_q4", exp4_q.size(), 0);
  endtask

  initial begin
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    #1;
    chk("rst_out_valid", out_valid3, 1'b0);
    chk("rst_out_data", out_data3, 32'h0);
    chk("rst_sel_err", sel_err3, 1'b0);
    chk("rst_err_cnt", err_cnt3, 8'd0);
    chk("rst_in_ready3", in_ready3, 1'b1);
    chk("rst_in_ready4", in_ready4, 1'b1);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat, in-range select
    send(2'd2);
    idle();
    drain();

    // Out-of-range select on the N=3 instance
    w[2] = 32'hABCD;
    send(2'd3);
    idle();
    drain();

    // Back-to-back stream
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    idle();
    drain();

    // Five-cycle output stall in the middle of a stream
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          for (int k = 0; k < 4; k++) w[k] = 32'(i * 256 + k + 1);
          send(2'(i % 4));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        a0 = acc_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_accepts", acc_cnt - a0, STALL_ACCEPTS);
        out_ready = 1'b1;
      end
    join
    idle();
    drain();

    // Error counter saturation
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 300; i++) send(2'd3);
    idle();
    idle();
    drain();
    chk("err_cnt_sat", err_cnt3, 8'd255);

    // Asynchronous reset mid-cycle with a beat held on the output
    out_ready = 1'b0;
    send(2'd1);
    idle();
    #2;
    rst_n = 1'b0;
    rst_pulses++;
    exp3_q.delete();
    exp4_q.delete();
    err_m = 0;
    #1;
    chk("async_out_valid", out_valid3, 1'b0);
    chk("async_out_data", out_data3, 32'h0);
    chk("async_err_cnt", err_cnt3, 8'd0);
    chk("async_in_ready", in_ready3, 1'b1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    w = '{32'h5A5A0000, 32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003};
    send(2'd1);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
